// File: rtl/serial_frame_shifter.sv
// serial_frame_shifter: double-buffered parallel-to-serial front end feeding
// the 1011 sequence detector. Words arrive over valid/ready and leave MSB-first
// on a registered line that rests at IDLE_LEVEL between frames, with an
// optional fixed gap of idle-level bits after every frame.
module serial_frame_shifter #(
    parameter int   DATA_WIDTH = 8,
    parameter int   GAP_CYCLES = 0,
    parameter logic IDLE_LEVEL = 1'b0
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [DATA_WIDTH-1:0] i_data_in,
    input  logic                  i_data_valid,
    output logic                  o_data_ready,
    output logic                  o_sequence_out,
    output logic                  o_busy,
    output logic                  o_frame_done
);

    localparam int            CW        = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT  = CW'(DATA_WIDTH - 1);
    localparam logic [CW-1:0] PRE_LAST  = CW'(DATA_WIDTH - 2);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [7:0]    GAP_LOAD  = 8'(GAP_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        GAP
    } state_t;

    state_t                r_state;
    state_t                w_nextState;
    logic [DATA_WIDTH-1:0] r_holdData;
    logic                  r_holdFull;
    logic [DATA_WIDTH-1:0] r_shift;
    logic [CW-1:0]         r_bitCnt;
    logic [7:0]            r_gapCnt;
    logic                  r_seqOut;
    logic                  r_busy;
    logic                  r_frameDone;

    logic w_accept;
    logic w_load;
    logic w_step;
    logic w_enterGap;
    logic w_gapTick;

    // The hold register is the only thing upstream ever waits on; reset masks it.
    assign o_data_ready   = !r_holdFull && !i_reset;
    assign w_accept       = i_data_valid && o_data_ready;
    assign o_sequence_out = r_seqOut;
    assign o_busy         = r_busy;
    assign o_frame_done   = r_frameDone;

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state decode; a load straight from SHIFT or GAP avoids an idle bubble.
    always_comb begin
        w_nextState = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_enterGap  = 1'b0;
        w_gapTick   = 1'b0;
        case (r_state)
            IDLE: begin
                if (r_holdFull) begin
                    w_load      = 1'b1;
                    w_nextState = SHIFT;
                end
            end
            SHIFT: begin
                if (r_bitCnt != LAST_BIT) begin
                    w_step = 1'b1;
                end else if (GAP_CYCLES > 0) begin
                    w_enterGap  = 1'b1;
                    w_nextState = GAP;
                end else if (r_holdFull) begin
                    w_load = 1'b1;
                end else begin
                    w_nextState = IDLE;
                end
            end
            GAP: begin
                if (r_gapCnt > 8'd1) begin
                    w_gapTick = 1'b1;
                end else if (r_holdFull) begin
                    w_load      = 1'b1;
                    w_nextState = SHIFT;
                end else begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    // Hold buffer: emptied by a load, refilled by an accepted word.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_holdFull <= 1'b0;
        end else if (w_load) begin
            r_holdFull <= 1'b0;
        end else if (w_accept) begin
            r_holdData <= i_data_in;
            r_holdFull <= 1'b1;
        end
    end

    // Serial datapath: line, busy and frame_done are registered together.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_shift     <= '0;
            r_bitCnt    <= '0;
            r_gapCnt    <= 8'd0;
            r_seqOut    <= IDLE_LEVEL;
            r_busy      <= 1'b0;
            r_frameDone <= 1'b0;
        end else begin
            r_frameDone <= 1'b0;
            if (w_load) begin
                r_shift  <= {r_holdData[DATA_WIDTH-2:0], 1'b0};
                r_seqOut <= r_holdData[DATA_WIDTH-1];
                r_busy   <= 1'b1;
                r_bitCnt <= '0;
            end else if (w_step) begin
                r_shift     <= {r_shift[DATA_WIDTH-2:0], 1'b0};
                r_seqOut    <= r_shift[DATA_WIDTH-1];
                r_bitCnt    <= r_bitCnt + CNT_ONE;
                r_frameDone <= (r_bitCnt == PRE_LAST);
            end else if (w_enterGap) begin
                r_seqOut <= IDLE_LEVEL;
                r_busy   <= 1'b1;
                r_gapCnt <= GAP_LOAD;
            end else if (w_gapTick) begin
                r_gapCnt <= r_gapCnt - 8'd1;
            end else begin
                r_seqOut <= IDLE_LEVEL;
                r_busy   <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_frame_shifter.sv
// Bench for serial_frame_shifter: one instance with no gap and one with a
// two-bit gap, both checked every cycle against a frame-schedule model.
module tb_serial_frame_shifter;

    logic       clk = 1'b0;
    logic       rst0, valid0, ready0, seq0, busy0, done0;
    logic       rst2, valid2, ready2, seq2, busy2, done2;
    logic [7:0] data0, data2;

    int   cyc = 0;
    int   testsRun = 0;
    int   testsFailed = 0;
    logic acc0 = 1'b0;
    logic acc2 = 1'b0;

    typedef struct {
        int         start;
        int         acc;
        logic [7:0] word;
    } frame_t;

    frame_t q0[$];
    frame_t q2[$];

    always #5 clk = ~clk;

    serial_frame_shifter #(.DATA_WIDTH(8), .GAP_CYCLES(0), .IDLE_LEVEL(1'b0)) dut0 (
        .i_clk(clk), .i_reset(rst0), .i_data_in(data0), .i_data_valid(valid0),
        .o_data_ready(ready0), .o_sequence_out(seq0), .o_busy(busy0), .o_frame_done(done0)
    );

    serial_frame_shifter #(.DATA_WIDTH(8), .GAP_CYCLES(2), .IDLE_LEVEL(1'b0)) dut2 (
        .i_clk(clk), .i_reset(rst2), .i_data_in(data2), .i_data_valid(valid2),
        .o_data_ready(ready2), .o_sequence_out(seq2), .o_busy(busy2), .o_frame_done(done2)
    );

    // Expected {ready, line, busy, done} in the cycle after edge e, derived from
    // the schedule of frames: each frame owns 8 data cycles then g gap cycles.
    function automatic logic [3:0] expect_out(input int sel, input int e);
        frame_t q[$];
        int     g;
        logic   rdy, s, b, d;
        if (sel == 0) begin
            q = q0; g = 0; rdy = !rst0;
        end else begin
            q = q2; g = 2; rdy = !rst2;
        end
        s = 1'b0; b = 1'b0; d = 1'b0;
        foreach (q[i]) begin
            if (q[i].acc <= e && q[i].start > e) rdy = 1'b0;
            if (e >= q[i].start && e <= q[i].start + 7) begin
                s = q[i].word[7 - (e - q[i].start)];
                b = 1'b1;
                d = (e == q[i].start + 7);
            end else if (e > q[i].start + 7 && e <= q[i].start + 7 + g) begin
                b = 1'b1;
            end
        end
        return {rdy, s, b, d};
    endfunction

    // Model update at each edge: reset wipes the schedule, an accepted word is
    // scheduled at the later of "next edge" and "previous frame plus gap done".
    always @(posedge clk) begin
        logic [3:0] pre0, pre2;
        frame_t     f;
        pre0 = expect_out(0, cyc);
        pre2 = expect_out(1, cyc);
        cyc  = cyc + 1;
        acc0 = 1'b0;
        acc2 = 1'b0;
        if (rst0) begin
            q0.delete();
        end else if (valid0 && pre0[3]) begin
            f.acc   = cyc;
            f.word  = data0;
            f.start = cyc + 1;
            if (q0.size() > 0 && q0[$].start + 8 > f.start) f.start = q0[$].start + 8;
            q0.push_back(f);
            acc0 = 1'b1;
        end
        if (rst2) begin
            q2.delete();
        end else if (valid2 && pre2[3]) begin
            f.acc   = cyc;
            f.word  = data2;
            f.start = cyc + 1;
            if (q2.size() > 0 && q2[$].start + 10 > f.start) f.start = q2[$].start + 10;
            q2.push_back(f);
            acc2 = 1'b1;
        end
    end

    // Reset held three cycles with valid high, then a word offered in the release cycle.
    task automatic test_reset;
        logic [7:0] obs, exp;
        rst0 = 1'b1; rst2 = 1'b1; valid0 = 1'b1; valid2 = 1'b1;
        data0 = 8'($urandom); data2 = 8'($urandom);
        for (int c = 0; c < 18; c++) begin
            @(negedge clk);
            testsRun++;
            exp = {expect_out(0, cyc), expect_out(1, cyc)};
            obs = {ready0, seq0, busy0, done0, ready2, seq2, busy2, done2};
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL reset cycle %0d: got %b want %b", cyc, obs, exp);
            end
            if (c < 2) begin
                data0 = 8'($urandom); data2 = 8'($urandom);
            end else if (c == 2) begin
                rst0 = 1'b0; rst2 = 1'b0; data0 = 8'h5A; data2 = 8'hC3;
            end else begin
                valid0 = 1'b0; valid2 = 1'b0;
            end
        end
    endtask

    // One word 8'hB4 on the no-gap instance.
    task automatic test_single;
        logic [7:0] obs, exp;
        valid0 = 1'b1; data0 = 8'hB4;
        for (int c = 0; c < 14; c++) begin
            @(negedge clk);
            testsRun++;
            exp = {expect_out(0, cyc), expect_out(1, cyc)};
            obs = {ready0, seq0, busy0, done0, ready2, seq2, busy2, done2};
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL single cycle %0d: got %b want %b", cyc, obs, exp);
            end
            if (acc0) valid0 = 1'b0;
        end
    endtask

    // Three words streamed with valid held high; also counts frame_done pulses.
    task automatic test_back_to_back;
        logic [7:0] obs, exp;
        logic [7:0] words[3];
        int         k, dones;
        words = '{8'hB0, 8'h0D, 8'hFF};
        k = 0; dones = 0;
        valid0 = 1'b1; data0 = words[0];
        for (int c = 0; c < 34; c++) begin
            @(negedge clk);
            testsRun++;
            exp = {expect_out(0, cyc), expect_out(1, cyc)};
            obs = {ready0, seq0, busy0, done0, ready2, seq2, busy2, done2};
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL back_to_back cycle %0d: got %b want %b", cyc, obs, exp);
            end
            if (done0 === 1'b1) dones++;
            if (acc0 && valid0) begin
                k++;
                if (k < 3) data0 = words[k];
                else valid0 = 1'b0;
            end
        end
        testsRun++;
        if (dones !== 3) begin
            testsFailed++;
            $display("[TB] FAIL back_to_back_done_count: got %0d want 3", dones);
        end
    endtask

    // Two random words back-to-back on the two-bit-gap instance.
    task automatic test_gap;
        logic [7:0] obs, exp;
        int         k;
        k = 0;
        valid2 = 1'b1; data2 = 8'($urandom);
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            testsRun++;
            exp = {expect_out(0, cyc), expect_out(1, cyc)};
            obs = {ready0, seq0, busy0, done0, ready2, seq2, busy2, done2};
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL gap cycle %0d: got %b want %b", cyc, obs, exp);
            end
            if (acc2 && valid2) begin
                k++;
                if (k < 2) data2 = 8'($urandom);
                else valid2 = 1'b0;
            end
        end
    endtask

    // Valid held high while data_in changes every cycle on both instances.
    task automatic test_backpressure;
        logic [7:0] obs, exp;
        valid0 = 1'b1; valid2 = 1'b1;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            testsRun++;
            exp = {expect_out(0, cyc), expect_out(1, cyc)};
            obs = {ready0, seq0, busy0, done0, ready2, seq2, busy2, done2};
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL backpressure cycle %0d: got %b want %b", cyc, obs, exp);
            end
            data0 = 8'($urandom); data2 = 8'($urandom);
            if (c >= 44) begin
                valid0 = 1'b0; valid2 = 1'b0;
            end
        end
    endtask

    // Reset after bit 3 of 8'hB4 with a second word held, then a fresh word.
    task automatic test_reset_mid;
        logic [7:0] obs, exp;
        int         k, rstAt;
        k = 0; rstAt = -1;
        valid0 = 1'b1; data0 = 8'hB4;
        for (int c = 0; c < 32; c++) begin
            @(negedge clk);
            testsRun++;
            exp = {expect_out(0, cyc), expect_out(1, cyc)};
            obs = {ready0, seq0, busy0, done0, ready2, seq2, busy2, done2};
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL reset_mid cycle %0d: got %b want %b", cyc, obs, exp);
            end
            if (acc0 && valid0) begin
                k++;
                if (k == 1) data0 = 8'($urandom);
                else valid0 = 1'b0;
            end
            if (rstAt < 0 && q0.size() > 0 && cyc == q0[0].start + 3) begin
                rst0 = 1'b1; rstAt = cyc;
            end else if (rstAt > 0 && cyc == rstAt + 2) begin
                rst0 = 1'b0; valid0 = 1'b1; data0 = 8'($urandom);
            end
        end
        valid0 = 1'b0;
    endtask

    // Random valid and data on both instances, then a drain.
    task automatic test_random;
        logic [7:0] obs, exp;
        for (int c = 0; c < 90; c++) begin
            @(negedge clk);
            testsRun++;
            exp = {expect_out(0, cyc), expect_out(1, cyc)};
            obs = {ready0, seq0, busy0, done0, ready2, seq2, busy2, done2};
            if (obs !== exp) begin
                testsFailed++;
                $display("[TB] FAIL random cycle %0d: got %b want %b", cyc, obs, exp);
            end
            valid0 = (c < 75) && ($urandom_range(0, 3) != 0);
            valid2 = (c < 75) && ($urandom_range(0, 2) != 0);
            data0  = 8'($urandom);
            data2  = 8'($urandom);
        end
    endtask

    initial begin
        rst0 = 1'b1; rst2 = 1'b1;
        valid0 = 1'b0; valid2 = 1'b0;
        data0 = 8'h00; data2 = 8'h00;
        test_reset();
        test_single();
        test_back_to_back();
        test_gap();
        test_backpressure();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/serial_frame_shifter.md
# serial_frame_shifter

Parallel-to-serial front end for the 1011 sequence-detector stage. It accepts W-bit words over a valid/ready handshake, double-buffers them, and emits them MSB-first, one bit per clock, on a registered serial line. That line connects directly to the detector's `sequence_in`. Between frames the line rests at a fixed idle level, with an optional fixed inter-frame gap, so the detector never sees undefined bits.

## Interface
- `DATA_WIDTH`, default 8: word width W; legal range 2..32.
- `GAP_CYCLES`, default 0: idle-level bits inserted after every frame; legal range 0..255.
- `IDLE_LEVEL`, default 1'b0: value driven on `sequence_out` when no data bit is being sent.

- `clock` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `data_in` in W: word to serialize; sampled on the edge where `data_valid && data_ready`.
- `data_valid` in 1: upstream offers `data_in`.
- `data_ready` out 1: hold buffer empty; a word can be accepted this cycle.
- `sequence_out` out 1: registered serial bit to the detector.
- `busy` out 1: high while a data bit or gap bit is on `sequence_out`.
- `frame_done` out 1: one-cycle pulse, high in the cycle the LSB of a word is on `sequence_out`.

## Operation
- **Storage:** one hold register (`hold_data`, `hold_full`), a W-bit shift register, a bit counter (ceil(log2 W) bits) and a gap counter (8 bits).
- **Handshake:** `data_ready = !hold_full && !reset`.
  - Acceptance on an edge with `data_valid && data_ready`: `hold_data <= data_in`, `hold_full <= 1`.
  - `data_in` is ignored when there is no acceptance.
- **FSM states:** IDLE, SHIFT, GAP.
  - **IDLE:** `sequence_out = IDLE_LEVEL`, `busy = 0`. When `hold_full` is set: load the shift register from the hold register, clear `hold_full`, set `bit_cnt = 0`, and on that same edge drive `sequence_out <= hold_data[W-1]`. Then go to SHIFT.
  - **SHIFT:** on each edge, drive the next bit and increment `bit_cnt`. When the LSB (bit index W-1 from MSB) has been driven, the exit depends on `GAP_CYCLES` and `hold_full`:
    - `GAP_CYCLES > 0`: go to GAP with `gap_cnt = GAP_CYCLES`.
    - `GAP_CYCLES == 0` and `hold_full`: load the next word on the very next edge. This is back-to-back: no bubble, the MSB directly follows the prior LSB.
    - Otherwise: go to IDLE.
  - **GAP:** drive `IDLE_LEVEL` and decrement `gap_cnt`. At zero, load directly if `hold_full`, else go to IDLE.
- **Throughput:** the hold register frees on the load edge, so `data_ready` rises the next cycle. Because W ≥ 2, a new word can always be accepted before the current frame ends, which sustains 100% line utilization.
- **Simultaneous events:**
  - Load and acceptance cannot coincide, because `data_ready` is low while `hold_full` is set.
  - An acceptance on the edge that takes the FSM SHIFT→IDLE is honoured, and the load occurs on the following edge.
- **Reset:** synchronous and dominant over all other inputs. A reset mid-frame aborts the frame: remaining bits and the held word are discarded, and no `frame_done` is issued.

## Timing
- **Reset values:**
  - `sequence_out = IDLE_LEVEL`
  - `busy = 0`
  - `frame_done = 0`
  - `data_ready = 0` while `reset` is high, and 1 in the first cycle after release
  - state IDLE, `hold_full = 0`
- **Latency:** a word accepted at edge N (from IDLE) drives its MSB from edge N+1. Bit i (MSB = 0) appears from edge N+1+i; the LSB appears from edge N+W.
- **`frame_done`:** high for exactly the cycle following edge N+W.
- **Back-to-back (`GAP_CYCLES = 0`):** the next word's MSB appears from edge N+W+1.
- **With gap:** idle-level bits occupy edges N+W+1 .. N+W+GAP_CYCLES, and the next MSB appears from edge N+W+GAP_CYCLES+1.
- **`busy`:** registered alongside `sequence_out`, so it is high exactly for data and gap bit cycles.

## Test plan
- **Reset values:** assert `reset` for 3 cycles, with `data_valid = 1` during reset and in the release cycle.
  - During reset: `data_ready = 0`, `sequence_out = 0`, `busy = 0`, `frame_done = 0`, and no word is accepted.
  - After release, `data_ready = 1`. The word offered in the release cycle is accepted and serialized with normal latency.
- **Single frame:** W=8, word 8'hB4 accepted at edge N.
  - `sequence_out` reads 1,0,1,1,0,1,0,0 from edges N+1..N+8, then 0.
  - `frame_done` is high only after edge N+8.
  - A downstream detector pulses one cycle after the fourth bit.
- **Back-to-back:** stream 8'hB0, 8'h0D, 8'hFF with `data_valid` held high. Required: 24 contiguous data bits with no idle bit, three `frame_done` pulses 8 cycles apart, and `data_ready` low for exactly the cycles `hold_full` is set.
- **Gap:** `GAP_CYCLES = 2`, two words back-to-back. Two `IDLE_LEVEL` bits separate the LSB of word 1 from the MSB of word 2, with `busy` high throughout.
- **Backpressure:** hold `data_valid` high with changing `data_in` while the hold register is full. Only the value present on the acceptance edge is serialized, and no word is duplicated or lost.
- **Reset mid-frame:** assert `reset` after bit 3 of 8'hB4 while a second word is held. Required:
  - `sequence_out = IDLE_LEVEL` from the reset edge
  - no `frame_done`
  - the held word is discarded
  - after release, a new word serializes with normal latency
